// File: rtl/ps2_mouse_host_fsm.sv
// Host-side PS/2 mouse controller: init sequence, retries, packet assembly.
// Define PS2_MOUSE_INTELLIMOUSE_EN to add the wheel knock and 4-byte packets.
module ps2_mouse_host_fsm #(
    parameter int         INIT_WAIT_CYCLES = 5000000,
    parameter int         TIMEOUT_CYCLES   = 50000000,
    parameter logic [7:0] SAMPLE_RATE      = 8'd100,
    parameter int         MAX_RETRIES      = 3
) (
    input  logic       CLK,
    input  logic       RESET,
    output logic       SEND_BYTE,
    output logic [7:0] BYTE_TO_SEND,
    input  logic       BYTE_SENT,
    output logic       READ_ENABLE,
    input  logic [7:0] BYTE_READ,
    input  logic [1:0] BYTE_ERROR_CODE,
    input  logic       BYTE_READY,
    output logic [7:0] MOUSE_STATUS,
    output logic [7:0] MOUSE_DX,
    output logic [7:0] MOUSE_DY,
    output logic [7:0] MOUSE_DZ,
    output logic       SEND_INTERRUPT,
    output logic       INIT_DONE,
    output logic       INIT_FAIL,
    output logic       WHEEL_PRESENT
);

    localparam logic [3:0] S_WAIT_INIT = 4'd0;
    localparam logic [3:0] S_WAIT_SENT = 4'd1;
    localparam logic [3:0] S_WAIT_ACK  = 4'd2;
    localparam logic [3:0] S_WAIT_AA   = 4'd3;
    localparam logic [3:0] S_WAIT_00   = 4'd4;
`ifdef PS2_MOUSE_INTELLIMOUSE_EN
    localparam logic [3:0] S_WAIT_ID   = 4'd5;
    localparam logic [3:0] ID_IDX      = 4'd7;
    localparam logic [3:0] LAST_IDX    = 4'd10;
`else
    localparam logic [3:0] LAST_IDX    = 4'd3;
`endif
    localparam logic [3:0] S_B0        = 4'd6;
    localparam logic [3:0] S_B1        = 4'd7;
    localparam logic [3:0] S_B2        = 4'd8;
    localparam logic [3:0] S_B3        = 4'd9;
    localparam logic [3:0] S_PUBLISH   = 4'd10;
    localparam logic [3:0] S_FAIL      = 4'd11;

    localparam logic [31:0] INIT_LIM = 32'(INIT_WAIT_CYCLES);
    localparam logic [31:0] TO_LIM   = 32'(TIMEOUT_CYCLES);

    logic [3:0]  state, state_n;
    logic [3:0]  cmd_idx, cmd_idx_n;
    logic [31:0] timer;
    logic [7:0]  retries;
    logic [7:0]  sh_status, sh_dx, sh_dy;
    logic        wheel;
    logic        tmo, good, last_try;
    logic        send_now, fail, reinit;
    logic        cap_b0, cap_b1, cap_b2;
    logic        re_n, stream_n, pub;
`ifdef PS2_MOUSE_INTELLIMOUSE_EN
    logic        id_wheel, id_plain;
`endif

    function automatic logic [7:0] cmd_byte(input logic [3:0] idx);
`ifdef PS2_MOUSE_INTELLIMOUSE_EN
        case (idx)
            4'd0:    cmd_byte = 8'hFF;
            4'd1:    cmd_byte = 8'hF3;
            4'd2:    cmd_byte = 8'hC8;
            4'd3:    cmd_byte = 8'hF3;
            4'd4:    cmd_byte = 8'h64;
            4'd5:    cmd_byte = 8'hF3;
            4'd6:    cmd_byte = 8'h50;
            4'd7:    cmd_byte = 8'hF2;
            4'd8:    cmd_byte = 8'hF3;
            4'd9:    cmd_byte = SAMPLE_RATE;
            default: cmd_byte = 8'hF4;
        endcase
`else
        case (idx)
            4'd0:    cmd_byte = 8'hFF;
            4'd1:    cmd_byte = 8'hF3;
            4'd2:    cmd_byte = SAMPLE_RATE;
            default: cmd_byte = 8'hF4;
        endcase
`endif
    endfunction

    assign tmo      = (timer >= TO_LIM);
    assign good     = BYTE_READY && (BYTE_ERROR_CODE == 2'b00);
    assign last_try = (int'(retries) + 1 >= MAX_RETRIES);
    assign WHEEL_PRESENT = wheel;

    always_comb begin
        state_n   = state;
        cmd_idx_n = cmd_idx;
        send_now  = 1'b0;
        fail      = 1'b0;
        reinit    = 1'b0;
        cap_b0    = 1'b0;
        cap_b1    = 1'b0;
        cap_b2    = 1'b0;
`ifdef PS2_MOUSE_INTELLIMOUSE_EN
        id_wheel  = 1'b0;
        id_plain  = 1'b0;
`endif
        unique case (state)
            S_WAIT_INIT: begin
                if (timer >= INIT_LIM) begin
                    cmd_idx_n = 4'd0;
                    send_now  = 1'b1;
                    state_n   = S_WAIT_SENT;
                end
            end
            S_WAIT_SENT: begin
                if (BYTE_SENT) state_n = S_WAIT_ACK;
                else if (tmo)  fail = 1'b1;
            end
            S_WAIT_ACK: begin
                if (BYTE_READY) begin
                    if (!good || BYTE_READ != 8'hFA) begin
                        fail = 1'b1;
                    end else if (cmd_idx == 4'd0) begin
                        state_n = S_WAIT_AA;
`ifdef PS2_MOUSE_INTELLIMOUSE_EN
                    end else if (cmd_idx == ID_IDX) begin
                        state_n = S_WAIT_ID;
`endif
                    end else if (cmd_idx == LAST_IDX) begin
                        state_n = S_B0;
                    end else begin
                        cmd_idx_n = cmd_idx + 4'd1;
                        send_now  = 1'b1;
                        state_n   = S_WAIT_SENT;
                    end
                end else if (tmo) begin
                    fail = 1'b1;
                end
            end
            S_WAIT_AA: begin
                if (BYTE_READY) begin
                    if (good && BYTE_READ == 8'hAA) state_n = S_WAIT_00;
                    else fail = 1'b1;
                end else if (tmo) begin
                    fail = 1'b1;
                end
            end
            S_WAIT_00: begin
                if (BYTE_READY) begin
                    if (good && BYTE_READ == 8'h00) begin
                        cmd_idx_n = cmd_idx + 4'd1;
                        send_now  = 1'b1;
                        state_n   = S_WAIT_SENT;
                    end else begin
                        fail = 1'b1;
                    end
                end else if (tmo) begin
                    fail = 1'b1;
                end
            end
`ifdef PS2_MOUSE_INTELLIMOUSE_EN
            S_WAIT_ID: begin
                if (BYTE_READY) begin
                    if (good && (BYTE_READ == 8'h03 || BYTE_READ == 8'h00)) begin
                        id_wheel  = (BYTE_READ == 8'h03);
                        id_plain  = (BYTE_READ == 8'h00);
                        cmd_idx_n = cmd_idx + 4'd1;
                        send_now  = 1'b1;
                        state_n   = S_WAIT_SENT;
                    end else begin
                        fail = 1'b1;
                    end
                end else if (tmo) begin
                    fail = 1'b1;
                end
            end
`endif
            // B0 hunts for the sync bit and never times out
            S_B0: begin
                if (BYTE_READY) begin
                    if (!good) begin
                        reinit = 1'b1;
                    end else if (BYTE_READ[3]) begin
                        cap_b0  = 1'b1;
                        state_n = S_B1;
                    end
                end
            end
            S_B1: begin
                if (BYTE_READY) begin
                    if (!good) reinit = 1'b1;
                    else begin
                        cap_b1  = 1'b1;
                        state_n = S_B2;
                    end
                end else if (tmo) begin
                    state_n = S_B0;
                end
            end
            S_B2: begin
                if (BYTE_READY) begin
                    if (!good) reinit = 1'b1;
                    else begin
                        cap_b2  = 1'b1;
                        state_n = wheel ? S_B3 : S_PUBLISH;
                    end
                end else if (tmo) begin
                    state_n = S_B0;
                end
            end
            S_B3: begin
                if (BYTE_READY) begin
                    if (!good) reinit = 1'b1;
                    else state_n = S_PUBLISH;
                end else if (tmo) begin
                    state_n = S_B0;
                end
            end
            S_PUBLISH: state_n = S_B0;
            S_FAIL:    state_n = S_FAIL;
            default:   reinit = 1'b1;
        endcase
        if (fail) state_n = last_try ? S_FAIL : S_WAIT_INIT;
        if (reinit) state_n = S_WAIT_INIT;

        stream_n = (state_n == S_B0) || (state_n == S_B1) ||
                   (state_n == S_B2) || (state_n == S_B3) ||
                   (state_n == S_PUBLISH);
        re_n = stream_n || (state_n == S_WAIT_ACK) ||
               (state_n == S_WAIT_AA) || (state_n == S_WAIT_00);
`ifdef PS2_MOUSE_INTELLIMOUSE_EN
        re_n = re_n || (state_n == S_WAIT_ID);
`endif
        pub = (state_n == S_PUBLISH) && (state != S_PUBLISH);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state          <= S_WAIT_INIT;
            cmd_idx        <= 4'd0;
            timer          <= '0;
            retries        <= 8'd0;
            sh_status      <= 8'd0;
            sh_dx          <= 8'd0;
            sh_dy          <= 8'd0;
            SEND_BYTE      <= 1'b0;
            BYTE_TO_SEND   <= 8'hFF;
            READ_ENABLE    <= 1'b0;
            MOUSE_STATUS   <= 8'd0;
            MOUSE_DX       <= 8'd0;
            MOUSE_DY       <= 8'd0;
            MOUSE_DZ       <= 8'd0;
            SEND_INTERRUPT <= 1'b0;
            INIT_DONE      <= 1'b0;
            INIT_FAIL      <= 1'b0;
`ifdef PS2_MOUSE_INTELLIMOUSE_EN
            wheel          <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            cmd_idx <= cmd_idx_n;
            if (state_n != state)  timer <= '0;
            else if (timer != '1)  timer <= timer + 32'd1;
            if (reinit)    retries <= 8'd0;
            else if (fail) retries <= retries + 8'd1;
            SEND_BYTE <= send_now;
            if (send_now) BYTE_TO_SEND <= cmd_byte(cmd_idx_n);
            READ_ENABLE <= re_n;
            INIT_DONE   <= stream_n;
            if (state_n == S_FAIL) INIT_FAIL <= 1'b1;
            if (cap_b0) sh_status <= BYTE_READ;
            if (cap_b1) sh_dx     <= BYTE_READ;
            if (cap_b2) sh_dy     <= BYTE_READ;
            // last byte is forwarded straight from the receiver
            SEND_INTERRUPT <= pub;
            if (pub) begin
                MOUSE_STATUS <= sh_status;
                MOUSE_DX     <= sh_dx;
                MOUSE_DY     <= (state == S_B2) ? BYTE_READ : sh_dy;
                MOUSE_DZ     <= (state == S_B3) ? BYTE_READ : 8'd0;
            end
`ifdef PS2_MOUSE_INTELLIMOUSE_EN
            if (id_wheel)      wheel <= 1'b1;
            else if (id_plain) wheel <= 1'b0;
`endif
        end
    end

`ifndef PS2_MOUSE_INTELLIMOUSE_EN
    assign wheel = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_mouse_host_fsm.sv
// Directed bench for ps2_mouse_host_fsm: init, packets, resync, retries.
// Honours PS2_MOUSE_INTELLIMOUSE_EN to follow the wheel init and 4-byte packets.
module tb_ps2_mouse_host_fsm;

    localparam int IW = 20;
    localparam int TO = 60;
    localparam int MR = 3;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       SEND_BYTE;
    logic [7:0] BYTE_TO_SEND;
    logic       BYTE_SENT = 1'b0;
    logic       READ_ENABLE;
    logic [7:0] BYTE_READ = 8'h00;
    logic [1:0] BYTE_ERROR_CODE = 2'b00;
    logic       BYTE_READY = 1'b0;
    logic [7:0] MOUSE_STATUS, MOUSE_DX, MOUSE_DY, MOUSE_DZ;
    logic       SEND_INTERRUPT, INIT_DONE, INIT_FAIL, WHEEL_PRESENT;

    int nvec = 0;
    int nerr = 0;

    always #5 CLK = ~CLK;

    ps2_mouse_host_fsm #(
        .INIT_WAIT_CYCLES(IW),
        .TIMEOUT_CYCLES(TO),
        .SAMPLE_RATE(8'd100),
        .MAX_RETRIES(MR)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .SEND_BYTE(SEND_BYTE),
        .BYTE_TO_SEND(BYTE_TO_SEND),
        .BYTE_SENT(BYTE_SENT),
        .READ_ENABLE(READ_ENABLE),
        .BYTE_READ(BYTE_READ),
        .BYTE_ERROR_CODE(BYTE_ERROR_CODE),
        .BYTE_READY(BYTE_READY),
        .MOUSE_STATUS(MOUSE_STATUS),
        .MOUSE_DX(MOUSE_DX),
        .MOUSE_DY(MOUSE_DY),
        .MOUSE_DZ(MOUSE_DZ),
        .SEND_INTERRUPT(SEND_INTERRUPT),
        .INIT_DONE(INIT_DONE),
        .INIT_FAIL(INIT_FAIL),
        .WHEEL_PRESENT(WHEEL_PRESENT)
    );

    typedef struct {
        logic [7:0] b;
        logic [1:0] e;
        logic       irq;
        logic [7:0] st;
        logic [7:0] dx;
        logic [7:0] dy;
        logic [7:0] dz;
    } vec_t;

    vec_t vt[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic rx(input logic [7:0] b, input logic [1:0] e);
        @(negedge CLK);
        BYTE_READ       = b;
        BYTE_ERROR_CODE = e;
        BYTE_READY      = 1'b1;
        @(negedge CLK);
        BYTE_READY      = 1'b0;
        BYTE_ERROR_CODE = 2'b00;
    endtask

    task automatic expect_cmd(input logic [7:0] exp, input int limit,
                              input bit ack_sent, output int cyc);
        cyc = 0;
        while (SEND_BYTE !== 1'b1 && cyc < limit) begin
            @(negedge CLK);
            cyc++;
        end
        check("send_seen", {31'd0, SEND_BYTE}, 32'd1);
        check("cmd_byte", {24'd0, BYTE_TO_SEND}, {24'd0, exp});
        if (ack_sent) begin
            @(negedge CLK);
            BYTE_SENT = 1'b1;
            @(negedge CLK);
            BYTE_SENT = 1'b0;
        end
    endtask

    task automatic cmd(input logic [7:0] exp, input logic [7:0] reply);
        int c;
        expect_cmd(exp, 400, 1'b1, c);
        check("read_en_ack", {31'd0, READ_ENABLE}, 32'd1);
        rx(reply, 2'b00);
    endtask

    task automatic init_after_ff();
        rx(8'hFA, 2'b00);
        rx(8'hAA, 2'b00);
        rx(8'h00, 2'b00);
`ifdef PS2_MOUSE_INTELLIMOUSE_EN
        cmd(8'hF3, 8'hFA);
        cmd(8'hC8, 8'hFA);
        cmd(8'hF3, 8'hFA);
        cmd(8'h64, 8'hFA);
        cmd(8'hF3, 8'hFA);
        cmd(8'h50, 8'hFA);
        cmd(8'hF2, 8'hFA);
        rx(8'h03, 2'b00);
`endif
        cmd(8'hF3, 8'hFA);
        cmd(8'h64, 8'hFA);
        check("init_done_pre", {31'd0, INIT_DONE}, 32'd0);
        cmd(8'hF4, 8'hFA);
        check("init_done", {31'd0, INIT_DONE}, 32'd1);
        check("read_en_stream", {31'd0, READ_ENABLE}, 32'd1);
    endtask

    task automatic init_seq();
        int c;
        expect_cmd(8'hFF, 400, 1'b1, c);
        init_after_ff();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_send"}, {31'd0, SEND_BYTE}, 32'd0);
        check({tag, "_tosend"}, {24'd0, BYTE_TO_SEND}, 32'hFF);
        check({tag, "_re"}, {31'd0, READ_ENABLE}, 32'd0);
        check({tag, "_pkt"}, {MOUSE_STATUS, MOUSE_DX, MOUSE_DY, MOUSE_DZ}, 32'd0);
        check({tag, "_irq"}, {31'd0, SEND_INTERRUPT}, 32'd0);
        check({tag, "_flags"}, {29'd0, INIT_DONE, INIT_FAIL, WHEEL_PRESENT}, 32'd0);
    endtask

    task automatic pkt_check(input string tag, input logic irq,
                             input logic [31:0] pkt);
        check({tag, "_irq"}, {31'd0, SEND_INTERRUPT}, {31'd0, irq});
        check({tag, "_pkt"}, {MOUSE_STATUS, MOUSE_DX, MOUSE_DY, MOUSE_DZ}, pkt);
    endtask

    initial begin
        int c;
        int pulses;

`ifdef PS2_MOUSE_INTELLIMOUSE_EN
        vt.push_back('{8'h08, 2'b00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00});
        vt.push_back('{8'h01, 2'b00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00});
        vt.push_back('{8'h02, 2'b00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00});
        vt.push_back('{8'hFF, 2'b00, 1'b1, 8'h08, 8'h01, 8'h02, 8'hFF});
        vt.push_back('{8'h00, 2'b00, 1'b0, 8'h08, 8'h01, 8'h02, 8'hFF});
        vt.push_back('{8'h09, 2'b00, 1'b0, 8'h08, 8'h01, 8'h02, 8'hFF});
        vt.push_back('{8'h03, 2'b00, 1'b0, 8'h08, 8'h01, 8'h02, 8'hFF});
        vt.push_back('{8'h04, 2'b00, 1'b0, 8'h08, 8'h01, 8'h02, 8'hFF});
        vt.push_back('{8'h05, 2'b00, 1'b1, 8'h09, 8'h03, 8'h04, 8'h05});
`else
        vt.push_back('{8'h08, 2'b00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00});
        vt.push_back('{8'h05, 2'b00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00});
        vt.push_back('{8'hFB, 2'b00, 1'b1, 8'h08, 8'h05, 8'hFB, 8'h00});
        vt.push_back('{8'h00, 2'b00, 1'b0, 8'h08, 8'h05, 8'hFB, 8'h00});
        vt.push_back('{8'h08, 2'b00, 1'b0, 8'h08, 8'h05, 8'hFB, 8'h00});
        vt.push_back('{8'h01, 2'b00, 1'b0, 8'h08, 8'h05, 8'hFB, 8'h00});
        vt.push_back('{8'h02, 2'b00, 1'b1, 8'h08, 8'h01, 8'h02, 8'h00});
        vt.push_back('{8'h2C, 2'b00, 1'b0, 8'h08, 8'h01, 8'h02, 8'h00});
        vt.push_back('{8'h80, 2'b00, 1'b0, 8'h08, 8'h01, 8'h02, 8'h00});
        vt.push_back('{8'h7F, 2'b00, 1'b1, 8'h2C, 8'h80, 8'h7F, 8'h00});
`endif

        tick(3);
        check_reset_vals("reset");
        RESET = 1'b0;

        init_seq();
`ifdef PS2_MOUSE_INTELLIMOUSE_EN
        check("wheel", {31'd0, WHEEL_PRESENT}, 32'd1);
`else
        check("wheel", {31'd0, WHEEL_PRESENT}, 32'd0);
`endif

        for (int i = 0; i < vt.size(); i++) begin
            rx(vt[i].b, vt[i].e);
            pkt_check($sformatf("vec%0d", i), vt[i].irq,
                      {vt[i].st, vt[i].dx, vt[i].dy, vt[i].dz});
            tick(1);
            check($sformatf("vec%0d_irq_drop", i), {31'd0, SEND_INTERRUPT}, 32'd0);
        end

        // gap timeout mid-packet drops the partial and resyncs at B0
        rx(8'h08, 2'b00);
        rx(8'h01, 2'b00);
        tick(TO + 10);
        rx(8'h08, 2'b00);
        rx(8'h0A, 2'b00);
`ifdef PS2_MOUSE_INTELLIMOUSE_EN
        rx(8'h0B, 2'b00);
        rx(8'h0C, 2'b00);
        pkt_check("gap", 1'b1, 32'h080A0B0C);
`else
        rx(8'h0B, 2'b00);
        pkt_check("gap", 1'b1, 32'h080A0B00);
`endif

        // receiver error mid-packet forces a full reinit
        rx(8'h08, 2'b00);
        check("err_done_pre", {31'd0, INIT_DONE}, 32'd1);
        rx(8'h05, 2'b01);
        check("err_done", {31'd0, INIT_DONE}, 32'd0);
        check("err_re", {31'd0, READ_ENABLE}, 32'd0);
        check("err_status_kept", {24'd0, MOUSE_STATUS}, 32'h08);
        expect_cmd(8'hFF, 400, 1'b1, c);
        check("err_ff_delay", {31'd0, (c >= IW)}, 32'd1);
        check("mid_re", {31'd0, READ_ENABLE}, 32'd1);

        RESET = 1'b1;
        tick(1);
        check_reset_vals("midreset");
        RESET = 1'b0;

        // three rejected resets exhaust retries
        for (int i = 0; i < MR; i++) begin
            cmd(8'hFF, 8'hFE);
            check($sformatf("retry%0d_fail", i), {31'd0, INIT_FAIL},
                  {31'd0, (i == MR - 1)});
        end
        check("fail_re", {31'd0, READ_ENABLE}, 32'd0);
        pulses = 0;
        for (int i = 0; i < IW + TO + 20; i++) begin
            @(negedge CLK);
            if (SEND_BYTE === 1'b1) pulses++;
        end
        check("fail_no_send", pulses, 32'd0);
        check("fail_sticky", {31'd0, INIT_FAIL}, 32'd1);

        RESET = 1'b1;
        tick(2);
        check("fail_cleared", {31'd0, INIT_FAIL}, 32'd0);
        RESET = 1'b0;

        // missing BYTE_SENT times out and retries the reset command
        expect_cmd(8'hFF, 400, 1'b0, c);
        tick(1);
        expect_cmd(8'hFF, 400, 1'b1, c);
        check("tmo_retry_delay", {31'd0, (c >= TO)}, 32'd1);
        init_after_ff();
        rx(8'h18, 2'b00);
        rx(8'h21, 2'b00);
        rx(8'h22, 2'b00);
`ifdef PS2_MOUSE_INTELLIMOUSE_EN
        rx(8'h23, 2'b00);
        pkt_check("post_retry", 1'b1, 32'h18212223);
`else
        pkt_check("post_retry", 1'b1, 32'h18212200);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
